// File: rtl/div_64b_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_64b_seq_pkg
//  Shared definitions for the multi-cycle SM2 arithmetic units: FSM state
//  encodings and default operand / counter widths.
// ---------------------------------------------------------------------------
package div_64b_seq_pkg;

   localparam int DIV_WIDTH_DEF = 64;
   localparam int DIV_CNT_W_DEF = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_64b_step.sv
// ---------------------------------------------------------------------------
// div_64b_step
//  One combinational radix-2 restoring division step.
//  Ports:
//    r_in     in  WIDTH  partial remainder (always < divisor)
//    q_msb    in  1      dividend bit shifted into the remainder this step
//    divisor  in  WIDTH  divisor (non-zero)
//    r_out    out WIDTH  new partial remainder
//    q_bit    out 1      quotient bit produced this step
// ---------------------------------------------------------------------------
module div_64b_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] r_in,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] r_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // The shifted remainder needs WIDTH+1 bits; the trial subtraction's top
   // bit is the borrow. Whichever value is kept is < divisor, so it fits
   // back into WIDTH bits.
   always_comb begin
      shifted = {r_in, q_msb};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[WIDTH];
      r_out   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_64b_seq.sv
// ---------------------------------------------------------------------------
// div_64b_seq
//  Sequential unsigned divider, radix-2 restoring, one quotient bit per
//  cycle. A result is presented WIDTH+1 cycles after acceptance (1 cycle for
//  divide-by-zero) and held until the consumer takes it.
//  Ports:
//    clk, rst              clock, async active-high reset
//    in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//    dividend, divisor     operands, sampled on in_valid & in_ready
//    out_valid / out_ready result handshake
//    quotient, remainder   result, held after handoff until the next result
//    div_zero              current result came from a zero divisor
//    busy                  high while computing or holding a result
// ---------------------------------------------------------------------------
module div_64b_seq
   import div_64b_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF,
   parameter int CNT_W = DIV_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero,
   output logic             busy
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs_q, dvs_d;       // captured divisor
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;

   div_64b_step #(.WIDTH(WIDTH)) u_step (
      .r_in    (rem_q),
      .q_msb   (quo_q[WIDTH-1]),
      .divisor (dvs_q),
      .r_out   (step_rem),
      .q_bit   (step_qbit)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               if (divisor == '0) begin
                  state_d     = ST_DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = ST_CALC;
                  cnt_d   = CNT_W'(WIDTH);
                  rem_d   = '0;
                  quo_d   = dividend;
                  dvs_d   = divisor;
               end
            end
         end
         ST_CALC: begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_qbit};
            cnt_d = cnt_q - 1'b1;
            // Last step: publish the result straight from the step outputs
            // so out_valid rises in the same edge the final bit is formed.
            if (cnt_q == CNT_W'(1)) begin
               state_d     = ST_DONE;
               quotient_d  = {quo_q[WIDTH-2:0], step_qbit};
               remainder_d = step_rem;
               div_zero_d  = 1'b0;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Handshake flags follow the next state so they stay registered.
      out_valid_d = (state_d == ST_DONE);
      in_ready_d  = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_div_64b_seq.sv
// Directed and random checks of div_64b_seq (WIDTH=64).
module tb_div_64b_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        in_ready, out_valid, div_zero, busy;
   logic [63:0] quotient, remainder;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_64b_seq #(.WIDTH(64), .CNT_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present operands for one edge; scramble them afterwards so a late
   // sample would be caught.
   task automatic start_op(input string tag, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = ~a;
      divisor  = ~b;
   endtask

   // Counts rising edges from the accept edge (inclusive) to out_valid.
   task automatic wait_result(input string tag, input int exp_lat);
      int n;
      n = 1;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic check_result(input string tag, input logic [63:0] q,
                               input logic [63:0] r, input logic dz);
      chk({tag, ".quotient"}, quotient, q);
      chk({tag, ".remainder"}, remainder, r);
      chk({tag, ".div_zero"}, 64'(div_zero), 64'(dz));
   endtask

   // out_ready is high: handoff at the next edge, then IDLE.
   task automatic handoff(input string tag);
      @(posedge clk);
      #1;
      chk({tag, ".post_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".post_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, ".post_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] q, input logic [63:0] r, input logic dz,
                          input int lat);
      start_op(tag, a, b);
      wait_result(tag, lat);
      check_result(tag, q, r, dz);
      handoff(tag);
   endtask

   initial begin
      logic [63:0] a, b, eq, er;

      // Reset state
      #12;
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      check_result("rst", 64'd0, 64'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Basic and boundary vectors
      start_op("d100_7", 64'd100, 64'd7);
      chk("d100_7.busy", 64'(busy), 64'd1);
      chk("d100_7.in_ready_busy", 64'(in_ready), 64'd0);
      wait_result("d100_7", 65);
      check_result("d100_7", 64'd14, 64'd2, 1'b0);
      handoff("d100_7");
      chk("d100_7.hold_q", quotient, 64'd14);

      run_div("max_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65);
      run_div("d5_9", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65);
      run_div("dz", 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1);
      run_div("max_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 65);
      run_div("top_2", 64'h8000_0000_0000_0001, 64'd2, 64'h4000_0000_0000_0000, 64'd1, 1'b0, 65);

      // Consumer stall in DONE while new operands are offered
      out_ready = 1'b0;
      start_op("stall", 64'd1000, 64'd3);
      wait_result("stall", 65);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = 64'd7;
         divisor  = 64'd0;
         @(posedge clk);
         #1;
         chk("stall.out_valid", 64'(out_valid), 64'd1);
         chk("stall.in_ready", 64'(in_ready), 64'd0);
         check_result("stall", 64'd333, 64'd1, 1'b0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      handoff("stall");
      check_result("stall.kept", 64'd333, 64'd1, 1'b0);

      // Reset in the middle of CALC
      start_op("abort", 64'hFFFF, 64'd3);
      repeat (29) @(posedge clk);
      #2;
      chk("abort.busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort.out_valid", 64'(out_valid), 64'd0);
      chk("abort.in_ready", 64'(in_ready), 64'd1);
      chk("abort.busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_div("after_abort", 64'd21, 64'd4, 64'd5, 64'd1, 1'b0, 65);

      // Random pairs: small divisors, large divisors, divisor > dividend
      for (int i = 0; i < 150; i++) begin
         a = {$urandom(), $urandom()};
         b = {$urandom(), $urandom()};
         case (i % 4)
            0: b = b >> $urandom_range(63, 0);
            1: a = a >> $urandom_range(63, 0);
            2: b = b | 64'h8000_0000_0000_0000;
            default: ;
         endcase
         if (b == 64'd0) b = 64'd3;
         eq = a / b;
         er = a % b;
         run_div("rand", a, b, eq, er, 1'b0, 65);
         chk("rand.rem_lt_div", 64'(remainder < b), 64'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
